// File: rtl/serdes_pkg.sv
// serdes_pkg: constants and state type shared by the serializer and deserializer
package serdes_pkg;
  localparam int DATA_W = 16;
  localparam int MIN_LEN = 3;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/serializer.sv
// serializer: parallel word to MSB-first serial bit stream with per-bit valid
module serializer
  import serdes_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int MOD_W = $clog2(DATA_W_P),
  parameter int MIN_LEN_P = MIN_LEN
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W_P-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              busy_o
);
  localparam logic [MOD_W:0] FULL = (MOD_W+1)'(DATA_W_P);
  state_t state;
  logic [DATA_W_P-1:0] sreg;
  logic [MOD_W:0] cnt, len;
  logic legal;
  assign legal = (data_mod_i == '0) || (data_mod_i >= MOD_W'(MIN_LEN_P));
  // accept a legal request in IDLE, then shift one bit per cycle until len bits are sent
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
      len   <= '0;
    end else if (state == IDLE) begin
      if (data_val_i && legal) begin
        state <= SHIFT;
        sreg  <= data_i;
        len   <= (data_mod_i == '0) ? FULL : {1'b0, data_mod_i};
        cnt   <= '0;
      end
    end else begin
      sreg  <= sreg << 1;
      state <= (cnt == len - 1'b1) ? IDLE : SHIFT;
      cnt   <= (cnt == len - 1'b1) ? '0 : cnt + 1'b1;
    end
  end
  // outputs decode registered state only, so reset clears them without a clock
  always_comb begin
    busy_o         = (state == SHIFT);
    ser_data_val_o = (state == SHIFT);
    ser_data_o     = (state == SHIFT) & sreg[DATA_W_P-1];
  end
endmodule

// File: tb/tb_serializer.sv
// tb_serializer: queue-based reference model plus directed and random stimulus
module tb_serializer;
  import serdes_pkg::*;
  logic clk = 0, rst = 1;
  logic [15:0] data = '0;
  logic [3:0] mod = '0;
  logic val = 0;
  logic sd, sv, busy;
  int total = 0, bad = 0;
  bit exp_q[$];
  bit exp_v, exp_b;
  logic [63:0] cap;
  int ncap, nbusy;

  serializer dut (
    .clk_i(clk), .srst_i(rst), .data_i(data), .data_mod_i(mod), .data_val_i(val),
    .ser_data_o(sd), .ser_data_val_o(sv), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // model: a word becomes a list of bits to emit, one per cycle, MSB first
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      exp_v = 0;
      exp_b = 0;
    end else begin
      if (!exp_v && val && (mod == 0 || mod >= MIN_LEN)) begin
        int n;
        n = (mod == 0) ? 16 : int'(mod);
        for (int k = 0; k < n; k++) exp_q.push_back(data[15-k]);
      end
      if (exp_q.size() > 0) begin
        exp_v = 1;
        exp_b = exp_q.pop_front();
      end else begin
        exp_v = 0;
        exp_b = 0;
      end
    end
  end

  // compare and capture on the inactive edge
  always @(negedge clk) begin
    check("val", sv, exp_v);
    check("bit", sd, exp_b);
    check("busy", busy, exp_v);
    if (sv) begin
      cap = {cap[62:0], sd};
      ncap++;
    end
    if (busy) nbusy++;
  end

  task automatic clr();
    cap = '0;
    ncap = 0;
    nbusy = 0;
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] m);
    @(negedge clk);
    data = d;
    mod = m;
    val = 1;
    @(negedge clk);
    val = 0;
    data = $urandom;
    mod = $urandom;
  endtask

  initial begin
    clr();
    repeat (3) @(negedge clk);
    check("rst_val", sv, 0);
    check("rst_busy", busy, 0);
    rst = 0;
    clr();
    send(16'hA5C3, 0);
    repeat (20) @(negedge clk);
    check("a5c3_word", cap[15:0], 16'hA5C3);
    check("a5c3_n", ncap, 16);
    check("a5c3_busy", nbusy, 16);
    clr();
    send(16'hF800, 5);
    repeat (8) @(negedge clk);
    check("f800_word", cap[4:0], 5'b11111);
    check("f800_n", ncap, 5);
    check("f800_busy", nbusy, 5);
    clr();
    send(16'hFFFF, 1);
    repeat (3) @(negedge clk);
    send(16'hFFFF, 2);
    repeat (3) @(negedge clk);
    check("illegal_n", ncap, 0);
    check("illegal_busy", nbusy, 0);
    clr();
    send(16'h8001, 0);
    repeat (3) @(negedge clk);
    send(16'hFFFF, 3);
    repeat (16) @(negedge clk);
    check("ignore_word", cap[15:0], 16'h8001);
    check("ignore_n", ncap, 16);
    send(16'hFFFF, 0);
    repeat (6) @(negedge clk);
    #2 rst = 1;
    #1;
    check("arst_val", sv, 0);
    check("arst_bit", sd, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    clr();
    send(16'h1234, 0);
    repeat (20) @(negedge clk);
    check("1234_word", cap[15:0], 16'h1234);
    check("1234_n", ncap, 16);
    clr();
    @(negedge clk);
    data = 16'hC000;
    mod = 4;
    val = 1;
    begin
      int i;
      for (i = 0; i < 100; i++) begin
        @(posedge clk);
        if (ncap >= 12) break;
      end
      check("held_timeout", i < 100, 1);
    end
    @(negedge clk);
    val = 0;
    check("held_stream", cap[11:0], 12'hCCC);
    repeat (8) @(negedge clk);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      data = $urandom;
      mod = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
      val = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 400) == 0) begin
        #2 rst = 1;
        #1 check("rnd_arst", {sv, sd, busy}, 3'b000);
        @(negedge clk);
        rst = 0;
      end
    end
    val = 0;
    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
